// File: rtl/merge_pkg.sv
// Shared types and helpers for the merge sorter load sequencer.
package merge_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_WAIT = 2'd1,
      ST_OUT  = 2'd2
   } merge_state_t;

   localparam int R2TO4_DEF  = 4;
   localparam int LAT_DEF    = 1;
   localparam int ONEHOT_MAX = 32;

   function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned pos);
      logic [ONEHOT_MAX-1:0] one;
      one = {{(ONEHOT_MAX-1){1'b0}}, 1'b1};
      return one << pos;
   endfunction

endpackage

// File: rtl/merge_load_ctrl.sv
// Steers one frame of sorted pairs into the 2-to-4 merge row, waits for the
// downstream rows to settle, then presents the merged frame until it is taken.
module merge_load_ctrl
   import merge_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int R2TO4 = R2TO4_DEF,
   parameter int LAT   = LAT_DEF,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [R2TO4-1:0] load,
   output logic             out_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic [CNTW-1:0]  frames_done
);

   localparam int IDXW   = $clog2(R2TO4);
   localparam int WAIT_W = 4;
   localparam logic [IDXW-1:0]   IDX_LAST  = IDXW'(R2TO4 - 1);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((LAT == 0) ? 0 : LAT - 1);

   if (WIDTH < 1 || R2TO4 < 2 || R2TO4 > ONEHOT_MAX || LAT < 0 || LAT > 15 || CNTW < 1)
   begin : g_param_check
      $error("merge_load_ctrl: illegal parameter combination");
   end

   merge_state_t      state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [WAIT_W-1:0] wcnt_q, wcnt_d;
   logic              out_q, out_d;
   logic [CNTW-1:0]   frames_q, frames_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_LOAD;
         idx_q    <= '0;
         wcnt_q   <= '0;
         out_q    <= 1'b0;
         frames_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         wcnt_q   <= wcnt_d;
         out_q    <= out_d;
         frames_q <= frames_d;
      end
   end

   // The row register captures on the accept edge, so load is driven combinationally.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      wcnt_d   = wcnt_q;
      out_d    = out_q;
      frames_d = frames_q;
      load     = '0;
      in_ready = (state_q == ST_LOAD) && !rst;

      if (flush) begin
         state_d = ST_LOAD;
         idx_d   = '0;
         wcnt_d  = '0;
         out_d   = 1'b0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (in_ready && in_valid) begin
                  load = R2TO4'(onehot(idx_q));
                  if (idx_q == IDX_LAST) begin
                     idx_d = '0;
                     if (LAT > 0) begin
                        state_d = ST_WAIT;
                        wcnt_d  = WAIT_INIT;
                     end else begin
                        state_d = ST_OUT;
                        out_d   = 1'b1;
                     end
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (wcnt_q == '0) begin
                  state_d = ST_OUT;
                  out_d   = 1'b1;
               end else begin
                  wcnt_d = wcnt_q - 1'b1;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  state_d  = ST_LOAD;
                  out_d    = 1'b0;
                  frames_d = frames_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_LOAD;
               out_d   = 1'b0;
            end
         endcase
      end
   end

   assign out_en      = out_q;
   assign out_valid   = out_q;
   assign busy        = !((state_q == ST_LOAD) && (idx_q == '0));
   assign frames_done = frames_q;

endmodule

// File: tb/tb_merge_load_ctrl.sv
// Bench for merge_load_ctrl: a LAT=1 instance and a LAT=0/CNTW=2 instance share
// stimulus and are both tracked by a frame-level reference model.
module tb_merge_load_ctrl;

   localparam int R = 4;

   logic clk, rst, in_valid, flush, out_ready;
   logic [R-1:0] load_a [2];
   logic         ir_a   [2];
   logic         oe_a   [2];
   logic         ov_a   [2];
   logic         busy_a [2];
   logic [15:0]  fd_big;
   logic [1:0]   fd_small;
   int           fd_a   [2];

   int checks = 0;
   int errors = 0;
   bit mon_en = 0;

   merge_load_ctrl #(.WIDTH(8), .R2TO4(R), .LAT(1), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a[0]), .flush(flush),
      .load(load_a[0]), .out_en(oe_a[0]), .out_valid(ov_a[0]), .out_ready(out_ready),
      .busy(busy_a[0]), .frames_done(fd_big)
   );

   merge_load_ctrl #(.WIDTH(8), .R2TO4(R), .LAT(0), .CNTW(2)) dut_l0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a[1]), .flush(flush),
      .load(load_a[1]), .out_en(oe_a[1]), .out_valid(ov_a[1]), .out_ready(out_ready),
      .busy(busy_a[1]), .frames_done(fd_small)
   );

   always_comb begin
      fd_a[0] = int'(fd_big);
      fd_a[1] = int'(fd_small);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: beats taken so far, idle settle cycles still owed,
   // whether a merged frame is being offered, and frames delivered.
   typedef struct {
      int beats;
      int settle;
      bit hold;
      int frames;
   } mdl_t;

   mdl_t m [2];

   function automatic mdl_t mdl_reset();
      mdl_t n;
      n.beats = 0; n.settle = 0; n.hold = 1'b0; n.frames = 0;
      return n;
   endfunction

   function automatic mdl_t mdl_next(mdl_t c, bit iv, bit fl, bit orr, int lat, int cntw);
      mdl_t n;
      bit   taking;
      n = c;
      taking = !c.hold && (c.settle == 0);
      if (fl) begin
         n.beats = 0; n.settle = 0; n.hold = 1'b0;
      end else if (taking && iv) begin
         if (c.beats == R - 1) begin
            n.beats = 0;
            if (lat > 0) n.settle = lat;
            else         n.hold = 1'b1;
         end else begin
            n.beats = c.beats + 1;
         end
      end else if (c.settle > 0) begin
         n.settle = c.settle - 1;
         if (n.settle == 0) n.hold = 1'b1;
      end else if (c.hold && orr) begin
         n.hold   = 1'b0;
         n.frames = (c.frames + 1) % (1 << cntw);
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m[0] <= mdl_reset();
         m[1] <= mdl_reset();
      end else begin
         m[0] <= mdl_next(m[0], in_valid, flush, out_ready, 1, 16);
         m[1] <= mdl_next(m[1], in_valid, flush, out_ready, 0, 2);
      end
   end

   bit           mon_taking;
   logic [R-1:0] mon_load;

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         for (int i = 0; i < 2; i++) begin
            mon_taking = !m[i].hold && (m[i].settle == 0);
            mon_load   = (mon_taking && in_valid && !flush) ? R'(1 << m[i].beats) : '0;
            checks += 6;
            if (ir_a[i] !== mon_taking) begin
               errors++; $display("FAIL mon_in_ready[%0d] t=%0t got %b want %b", i, $time, ir_a[i], mon_taking);
            end
            if (load_a[i] !== mon_load) begin
               errors++; $display("FAIL mon_load[%0d] t=%0t got %b want %b", i, $time, load_a[i], mon_load);
            end
            if (oe_a[i] !== m[i].hold) begin
               errors++; $display("FAIL mon_out_en[%0d] t=%0t got %b want %b", i, $time, oe_a[i], m[i].hold);
            end
            if (ov_a[i] !== m[i].hold) begin
               errors++; $display("FAIL mon_out_valid[%0d] t=%0t got %b want %b", i, $time, ov_a[i], m[i].hold);
            end
            if (busy_a[i] !== !(mon_taking && m[i].beats == 0)) begin
               errors++; $display("FAIL mon_busy[%0d] t=%0t got %b want %b", i, $time, busy_a[i], !(mon_taking && m[i].beats == 0));
            end
            if (fd_a[i] !== m[i].frames) begin
               errors++; $display("FAIL mon_frames[%0d] t=%0t got %0d want %0d", i, $time, fd_a[i], m[i].frames);
            end
            checks += 2;
            if (!$onehot0(load_a[i])) begin
               errors++; $display("FAIL inv_onehot[%0d] t=%0t got %b want at most one bit", i, $time, load_a[i]);
            end
            if ((load_a[i] != '0) && oe_a[i]) begin
               errors++; $display("FAIL inv_load_out[%0d] t=%0t got load %b with out_en 1, want load 0", i, $time, load_a[i]);
            end
         end
      end
   end

   task automatic cyc(input bit iv, input bit fl, input bit orr);
      @(posedge clk);
      #1;
      in_valid = iv; flush = fl; out_ready = orr;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      in_valid = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (load_a[i] !== '0 || oe_a[i] !== 1'b0 || ov_a[i] !== 1'b0 || busy_a[i] !== 1'b0 || ir_a[i] !== 1'b0) begin
            errors++; $display("FAIL reset_outputs[%0d] got load=%b oe=%b ov=%b busy=%b ir=%b want all 0", i, load_a[i], oe_a[i], ov_a[i], busy_a[i], ir_a[i]);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (fd_a[i] !== 0) begin
            errors++; $display("FAIL reset_frames[%0d] got %0d want 0", i, fd_a[i]);
         end
      end
      #2 rst = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (ir_a[i] !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready[%0d] got %b want 1", i, ir_a[i]);
         end
      end
      mon_en = 1'b1;
   endtask

   task automatic test_normal();
      int f0, f1;
      f0 = fd_a[0]; f1 = fd_a[1];
      for (int b = 0; b < R; b++) begin
         cyc(1'b1, 1'b0, 1'b1);
         @(negedge clk);
         checks++;
         if (load_a[0] !== R'(1 << b)) begin
            errors++; $display("FAIL normal_load beat%0d got %b want %b", b, load_a[0], R'(1 << b));
         end
      end
      cyc(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks += 2;
      if (oe_a[0] !== 1'b0 || ir_a[0] !== 1'b0) begin
         errors++; $display("FAIL normal_wait got oe=%b ir=%b want 0 0", oe_a[0], ir_a[0]);
      end
      if (ov_a[1] !== 1'b1) begin
         errors++; $display("FAIL lat0_out_next got %b want 1", ov_a[1]);
      end
      cyc(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks += 2;
      if (oe_a[0] !== 1'b1 || ov_a[0] !== 1'b1) begin
         errors++; $display("FAIL normal_out got oe=%b ov=%b want 1 1", oe_a[0], ov_a[0]);
      end
      if (fd_a[1] !== (f1 + 1) % 4) begin
         errors++; $display("FAIL lat0_frames got %0d want %0d", fd_a[1], (f1 + 1) % 4);
      end
      cyc(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (ov_a[0] !== 1'b0 || ir_a[0] !== 1'b1 || fd_a[0] !== f0 + 1) begin
         errors++; $display("FAIL normal_handoff got ov=%b ir=%b frames=%0d want 0 1 %0d", ov_a[0], ir_a[0], fd_a[0], f0 + 1);
      end
   endtask

   task automatic test_backpressure();
      int f0;
      f0 = fd_a[0];
      for (int b = 0; b < R; b++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 1'b0, 1'b0);
         @(negedge clk);
         checks++;
         if (ov_a[0] !== 1'b1 || ir_a[0] !== 1'b0 || load_a[0] !== '0) begin
            errors++; $display("FAIL bp_hold cycle%0d got ov=%b ir=%b load=%b want 1 0 0000", k, ov_a[0], ir_a[0], load_a[0]);
         end
      end
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (ov_a[0] !== 1'b0 || ir_a[0] !== 1'b1 || fd_a[0] !== f0 + 1) begin
         errors++; $display("FAIL bp_release got ov=%b ir=%b frames=%0d want 0 1 %0d", ov_a[0], ir_a[0], fd_a[0], f0 + 1);
      end
      idle(2);
   endtask

   task automatic test_gapped();
      for (int k = 0; k < 2 * R; k++) begin
         cyc(k % 2 == 0, 1'b0, 1'b1);
         @(negedge clk);
         checks++;
         if (load_a[0] !== ((k % 2 == 0) ? R'(1 << (k / 2)) : R'(0))) begin
            errors++; $display("FAIL gapped_load step%0d got %b want %b", k, load_a[0], ((k % 2 == 0) ? R'(1 << (k / 2)) : R'(0)));
         end
      end
      checks++;
      if (ir_a[0] !== 1'b0) begin
         errors++; $display("FAIL gapped_complete got in_ready=%b want 0", ir_a[0]);
      end
      idle(3);
   endtask

   task automatic test_flush();
      int f0, f1;
      f0 = fd_a[0]; f1 = fd_a[1];
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if (load_a[0] !== '0 || load_a[1] !== '0) begin
         errors++; $display("FAIL flush_load got %b/%b want 0000", load_a[0], load_a[1]);
      end
      cyc(1'b1, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (load_a[0] !== 4'b0001 || fd_a[0] !== f0 || fd_a[1] !== f1) begin
         errors++; $display("FAIL flush_restart got load=%b frames=%0d want 0001 %0d", load_a[0], fd_a[0], f0);
      end
      for (int b = 1; b < R; b++) cyc(1'b1, 1'b0, 1'b1);
      idle(3);
      f0 = fd_a[0]; f1 = fd_a[1];
      for (int b = 0; b < R; b++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (ov_a[0] !== 1'b1 || ov_a[1] !== 1'b1) begin
         errors++; $display("FAIL flush_out_entry got %b/%b want 1/1", ov_a[0], ov_a[1]);
      end
      cyc(1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (ov_a[0] !== 1'b0 || fd_a[0] !== f0 || fd_a[1] !== f1 || ir_a[0] !== 1'b1) begin
         errors++; $display("FAIL flush_out got ov=%b frames=%0d/%0d ir=%b want 0 %0d/%0d 1", ov_a[0], fd_a[0], fd_a[1], ir_a[0], f0, f1);
      end
   endtask

   task automatic test_async_reset();
      for (int b = 0; b < R; b++) cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (busy_a[0] !== 1'b1 || oe_a[0] !== 1'b0) begin
         errors++; $display("FAIL areset_inwait got busy=%b oe=%b want 1 0", busy_a[0], oe_a[0]);
      end
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (busy_a[i] !== 1'b0 || oe_a[i] !== 1'b0 || ov_a[i] !== 1'b0 || fd_a[i] !== 0) begin
            errors++; $display("FAIL areset_clear[%0d] got busy=%b oe=%b ov=%b frames=%0d want 0 0 0 0", i, busy_a[i], oe_a[i], ov_a[i], fd_a[i]);
         end
      end
      #1 rst = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (ir_a[i] !== 1'b1 || fd_a[i] !== 0) begin
            errors++; $display("FAIL areset_release[%0d] got ir=%b frames=%0d want 1 0", i, ir_a[i], fd_a[i]);
         end
      end
   endtask

   task automatic test_lat0_wrap();
      for (int f = 0; f < 4; f++) begin
         for (int b = 0; b < R; b++) cyc(1'b1, 1'b0, 1'b1);
         cyc(1'b0, 1'b0, 1'b1);
         @(negedge clk);
         checks++;
         if (ov_a[1] !== 1'b1) begin
            errors++; $display("FAIL lat0_out frame%0d got %b want 1", f, ov_a[1]);
         end
         idle(3);
         @(negedge clk);
         checks++;
         if (fd_a[1] !== (f + 1) % 4 || fd_a[0] !== f + 1) begin
            errors++; $display("FAIL wrap_count frame%0d got %0d/%0d want %0d/%0d", f, fd_a[1], fd_a[0], (f + 1) % 4, f + 1);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         cyc($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
      end
      cyc(1'b0, 1'b1, 1'b1);
      idle(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired: got no completion, want finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      test_reset();
      test_normal();
      test_backpressure();
      test_gapped();
      test_flush();
      test_async_reset();
      test_lat0_wrap();
      test_random();
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/merge_load_ctrl.md
Name: merge_load_ctrl

Overview:
- Sequencer for the merge sorter datapath: accepts one frame of R2TO4 sorted pairs over a valid/ready handshake and steers each beat into the 2-to-4 merge row with a one-hot load strobe.
- Waits a fixed settle latency for the 4-to-8 and 8-to-16 rows, then enables the output tristate buffer and holds the merged result until the consumer takes it.
- Sits between the symbol/pair source and the merge datapath; owns the merge row `load` vector and the output buffer enable.

Parameters:
- WIDTH, 8, element width in bits; carried for consistency and not used internally.
- R2TO4, 4, beats per frame; width of `load`; must be ≥2.
- LAT, 1, idle cycles between the last load and output enable (0..15).
- CNTW, 16, width of the frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  source presents a pair on the datapath `inba` bus this cycle.
- in_ready  out  1  controller accepts a beat this cycle.
- flush  in  1  synchronous abort of the current frame.
- load  out  R2TO4  one-hot load strobe to the merge row register slots.
- out_en  out  1  output tristate buffer enable.
- out_valid  out  1  merged frame on `c` is valid.
- out_ready  in  1  consumer takes the frame.
- busy  out  1  high in any state other than LOAD with beat index 0.
- frames_done  out  CNTW  count of delivered frames; wraps modulo 2^CNTW.

Behaviour:
- Reset (async, rst=1): state=LOAD, beat index idx=0, wait counter=0, frames_done=0. Outputs: load=0, out_en=0, out_valid=0, busy=0, in_ready=1 once rst deasserts.
- State LOAD:
  - in_ready=1.
  - load is combinational: load = (in_valid ? 1<<idx : 0). The datapath captures on the same edge, so the accept cycle equals the load cycle.
  - On accept with idx<R2TO4-1: idx++.
  - On accept with idx=R2TO4-1: idx←0, then go to WAIT if LAT>0, else go directly to OUT.
- State WAIT:
  - in_ready=0, load=0.
  - Wait counter loads LAT-1 on entry and decrements; at 0 go to OUT.
  - Net timing: the last beat is accepted at edge t; out_valid first goes high in the cycle after edge t+LAT.
- State OUT:
  - in_ready=0, load=0, out_en=1, out_valid=1, all registered.
  - out_valid stays high until out_ready=1 is sampled.
  - On that edge: frames_done++, go to LOAD; out_en and out_valid drop in the next cycle.
  - The next frame's first beat can be accepted in the cycle after the handoff, giving no bubble beyond one cycle.
- in_valid outside LOAD is ignored: no load pulse and no state change. The source must hold its data.
- flush (synchronous, any state): next state=LOAD, idx=0, wait counter cleared, out_en=0, out_valid=0, load forced to 0 in that cycle.
  - flush has priority over in_valid and over out_ready in the same cycle; the frame is not counted.
- Reset asserted mid-frame clears everything immediately (async); partial loads in the datapath are don't-care.
- Invariants:
  - load is never more than one-hot.
  - load is never nonzero while out_en=1.
  - out_en and out_valid are always equal.
- frames_done wraps 2^CNTW-1 → 0 with no flag.

Decomposition:
- Shared package `merge_pkg`:
  - State encoding typedef (LOAD, WAIT, OUT).
  - Default constants R2TO4_DEF=4, LAT_DEF=1.
  - onehot function used for `load`.
- Optional sub-module `merge_beat_cnt`: idx counter with wrap flag and a generic down-counter for WAIT. Otherwise the block is one FSM module.

Test Plan:
- Normal frame (LAT=1): 4 back-to-back beats with out_ready=1.
  - load sequence is 0001, 0010, 0100, 1000 on 4 consecutive cycles.
  - One WAIT cycle follows, then out_en=out_valid=1 for 1 cycle.
  - frames_done=1; in_ready is high again the following cycle.
- Backpressure: out_ready=0 for 5 cycles after OUT entry.
  - out_valid is held for 5 cycles, with in_ready=0 and load=0 throughout.
  - Raising out_ready gives frames_done+1 and a return to LOAD.
- Gapped input: in_valid toggles 1,0,1,0,...
  - load pulses occur only on valid cycles.
  - idx advances only on accepts; the frame completes after the 4th accept.
- Flush: assert flush together with the 3rd beat.
  - load=0 in that cycle and idx→0.
  - The next frame starts at load=0001; frames_done is unchanged.
  - Repeat the check with flush asserted together with out_ready in OUT: frame not counted.
- Async reset mid-WAIT: pulse rst between clock edges.
  - Outputs clear immediately.
  - After release, in_ready=1 and frames_done=0.
- LAT=0 and frames_done wrap (CNTW=2):
  - OUT is entered the cycle after the 4th load.
  - After 4 frames, frames_done reads 0.
